// File: rtl/sfx_scheduler.sv
// sfx_scheduler: fixed-priority preemptive sharing of one tone path among click/err/beep/finish; a request is granted on the next edge.
// Requests are latched (err/beep/finish) or dropped (click); `define SFX_DROP_CNT_EN adds the saturating dropped-click counter drop_cnt.
`timescale 1ns/1ps
module sfx_scheduler #(
   parameter int CLK_HZ      = 100000000,
   parameter int TICK_MS     = 10,
   parameter int CLICK_TICKS = 3,
   parameter int BUZZ_TICKS  = 15,
   parameter int BEEP_TICKS  = 20,
   parameter int NOTE_TICKS  = 12,
   parameter int GAP_TICKS   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sfx_en,
   input  logic [4:0]  vol_in,
   input  logic        req_click,
   input  logic        req_err,
   input  logic        req_beep,
   input  logic        req_finish,
   output logic [11:0] tone_hz,
   output logic [4:0]  tone_vol,
   output logic        busy,
   output logic [1:0]  active_src
`ifdef SFX_DROP_CNT_EN
   ,
   output logic [7:0]  drop_cnt
`endif
);

   localparam int TICK_CYC = CLK_HZ / 1000 * TICK_MS;
   localparam int TCW      = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

   localparam logic [1:0] SRC_CLICK = 2'd0;
   localparam logic [1:0] SRC_ERR   = 2'd1;
   localparam logic [1:0] SRC_BEEP  = 2'd2;
   localparam logic [1:0] SRC_FIN   = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [TCW-1:0] tick_cnt;
   logic           tick;
   logic [7:0]     dur_cnt, dur_nxt;
   logic [1:0]     note_idx, note_nxt;
   logic           pend_err, pend_beep, pend_fin;
   logic           pend_err_nxt, pend_beep_nxt, pend_fin_nxt;
   logic [11:0]    hz_nxt;
   logic [4:0]     vol_nxt;
   logic [1:0]     src_nxt;
   logic           want_click, want_err, want_beep, want_fin;
   logic           any_want, grant;
   logic [1:0]     best;

   // Priority order differs from the source encoding, so compare by rank.
   function automatic logic [1:0] rank_of(input logic [1:0] src);
      case (src)
         SRC_FIN:  rank_of = 2'd3;
         SRC_ERR:  rank_of = 2'd2;
         SRC_BEEP: rank_of = 2'd1;
         default:  rank_of = 2'd0;
      endcase
   endfunction

   function automatic logic [11:0] tone_of(input logic [1:0] src, input logic [1:0] note);
      case (src)
         SRC_CLICK: tone_of = 12'd2000;
         SRC_ERR:   tone_of = 12'd220;
         SRC_BEEP:  tone_of = 12'd880;
         default: begin
            case (note)
               2'd0:    tone_of = 12'd523;
               2'd1:    tone_of = 12'd659;
               2'd2:    tone_of = 12'd784;
               default: tone_of = 12'd1047;
            endcase
         end
      endcase
   endfunction

   function automatic logic [7:0] dur_of(input logic [1:0] src);
      case (src)
         SRC_CLICK: dur_of = 8'(CLICK_TICKS);
         SRC_ERR:   dur_of = 8'(BUZZ_TICKS);
         SRC_BEEP:  dur_of = 8'(BEEP_TICKS);
         default:   dur_of = 8'(NOTE_TICKS);
      endcase
   endfunction

   assign tick = sfx_en && (tick_cnt == TCW'(TICK_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tick_cnt <= '0;
      else if (!sfx_en || tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TCW'(1);
   end

   always_comb begin
      want_click = sfx_en & req_click;
      want_err   = sfx_en & (pend_err | req_err);
      want_beep  = sfx_en & (pend_beep | req_beep);
      want_fin   = sfx_en & (pend_fin | req_finish);
      any_want   = want_click | want_err | want_beep | want_fin;
      best       = SRC_CLICK;
      if (want_fin)
         best = SRC_FIN;
      else if (want_err)
         best = SRC_ERR;
      else if (want_beep)
         best = SRC_BEEP;
      // Equal rank in PLAY is only possible for the playing source itself: a retrigger.
      grant = any_want && ((state == IDLE) ||
                           (rank_of(best) > rank_of(active_src)) ||
                           ((state == PLAY) && (best == active_src)));
   end

   always_comb begin
      state_nxt     = state;
      dur_nxt       = dur_cnt;
      note_nxt      = note_idx;
      hz_nxt        = tone_hz;
      vol_nxt       = tone_vol;
      src_nxt       = active_src;
      pend_err_nxt  = want_err;
      pend_beep_nxt = want_beep;
      pend_fin_nxt  = want_fin;
      if (!sfx_en) begin
         state_nxt = IDLE;
         dur_nxt   = '0;
         note_nxt  = '0;
         hz_nxt    = '0;
      end else if (grant) begin
         state_nxt = PLAY;
         dur_nxt   = '0;
         note_nxt  = '0;
         src_nxt   = best;
         vol_nxt   = vol_in;
         hz_nxt    = tone_of(best, 2'd0);
         case (best)
            SRC_ERR:  pend_err_nxt  = 1'b0;
            SRC_BEEP: pend_beep_nxt = 1'b0;
            SRC_FIN:  pend_fin_nxt  = 1'b0;
            default:  ;
         endcase
      end else if (tick) begin
         case (state)
            PLAY: begin
               if (dur_cnt == dur_of(active_src) - 8'd1) begin
                  state_nxt = GAP;
                  dur_nxt   = '0;
                  hz_nxt    = '0;
               end else begin
                  dur_nxt = dur_cnt + 8'd1;
               end
            end
            GAP: begin
               if (dur_cnt == 8'(GAP_TICKS - 1)) begin
                  dur_nxt = '0;
                  if ((active_src == SRC_FIN) && (note_idx != 2'd3)) begin
                     state_nxt = PLAY;
                     note_nxt  = note_idx + 2'd1;
                     hz_nxt    = tone_of(SRC_FIN, note_idx + 2'd1);
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  dur_nxt = dur_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         dur_cnt    <= '0;
         note_idx   <= '0;
         pend_err   <= 1'b0;
         pend_beep  <= 1'b0;
         pend_fin   <= 1'b0;
         tone_hz    <= '0;
         tone_vol   <= '0;
         active_src <= '0;
      end else begin
         state      <= state_nxt;
         dur_cnt    <= dur_nxt;
         note_idx   <= note_nxt;
         pend_err   <= pend_err_nxt;
         pend_beep  <= pend_beep_nxt;
         pend_fin   <= pend_fin_nxt;
         tone_hz    <= hz_nxt;
         tone_vol   <= vol_nxt;
         active_src <= src_nxt;
      end
   end

   assign busy = (state != IDLE);

`ifdef SFX_DROP_CNT_EN
   logic click_drop;
   assign click_drop = want_click && !(grant && (best == SRC_CLICK));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drop_cnt <= '0;
      else if (!sfx_en)
         drop_cnt <= '0;
      else if (click_drop && (drop_cnt != 8'hFF))
         drop_cnt <= drop_cnt + 8'd1;
   end
`endif

endmodule
